// File: rtl/main_ctrl_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath.
// master = controller side, slave = datapath / conditional-execution side.
interface main_ctrl_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic [3:0] state_o;

    modport master (
        input  Op, Funct,
        output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, state_o
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, state_o
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Moore main controller for the multicycle ARM datapath: sequences fetch, decode, execute,
// memory and writeback states and drives datapath selects and write strobes.
module main_ctrl_fsm #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic            clk,
    input  logic            reset,
    main_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    localparam logic [3:0] WaitCnt = 4'(FETCH_WAIT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_fetch;

    logic       irwrite, nextpc, regw, memw, branch;
    logic       adrsrc, alusrca, aluop;
    logic [1:0] alusrcb, resultsrc;

    // Only I (bit 5) and S/L (bit 0) steer the sequence.
    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    assign last_fetch = (cnt_q == WaitCnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is zero everywhere outside FETCH, so FETCH is always entered with a clean count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            StFetch: begin
                if (last_fetch) begin
                    state_d = StDecode;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDecode: begin
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? StExecuteI : StExecuteR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = bus.Funct[0] ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        irwrite   = 1'b0;
        nextpc    = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        aluop     = 1'b0;
        case (state_q)
            StFetch: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = last_fetch;
                nextpc    = last_fetch;
            end
            StDecode: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            StMemAdr: begin
                alusrcb = 2'b01;
            end
            StMemRead: begin
                adrsrc = 1'b1;
            end
            StMemWb: begin
                resultsrc = 2'b01;
                regw      = 1'b1;
            end
            StMemWrite: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
            end
            StExecuteR: begin
                aluop = 1'b1;
            end
            StExecuteI: begin
                alusrcb = 2'b01;
                aluop   = 1'b1;
            end
            StAluWb: begin
                regw = 1'b1;
            end
            StBranch: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                branch    = 1'b1;
            end
            default: begin
                // Illegal codes: FETCH selects, no strobes, recover on the next edge.
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
        endcase
    end

    // Reset kills any in-flight strobe immediately rather than at the next edge.
    assign bus.IRWrite   = irwrite & ~reset;
    assign bus.NextPC    = nextpc & ~reset;
    assign bus.RegW      = regw & ~reset;
    assign bus.MemW      = memw & ~reset;
    assign bus.Branch    = branch & ~reset;
    assign bus.AdrSrc    = adrsrc;
    assign bus.ALUSrcA   = alusrca;
    assign bus.ALUSrcB   = alusrcb;
    assign bus.ResultSrc = resultsrc;
    assign bus.ALUOp     = aluop;
    assign bus.state_o   = state_q;

    // Downstream condition logic relies on at most one write-type request per cycle.
    a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({regw, memw, branch}));

    a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt_q <= WaitCnt);

endmodule
